msg_decrypt_engine: RTL and testbench
=====================================

// Module: msg_decrypt_engine
// PURPOSE
//  Hardware decryptor for LFSR-encrypted messages: the inverse of message encryption (Program 1).
//  Reads 64 encrypted bytes from data memory at DM[64..127].
//  Recovers the LFSR seed and which of the 9 tap patterns was used, then decrypts.
//  Strips the leading space preamble and writes the plaintext ASCII to DM[0..63].
//  Sits beside top_level as a DM bus master; only one master is active per run.
// PARAMETERS
//  MSG_BASE   64  DM address of encrypted byte 0
//  MSG_LEN    64  encrypted bytes per message
//  MAX_PRE    15  maximum leading spaces stripped
//  HDR_LEN     7  preamble bytes used for pattern search (seed byte + 6)
// PORTS
//  clk          in   1  clock; all logic on rising edge
//  init         in   1  synchronous active-high reset
//  req          in   1  high = hold idle; 1->0 transition launches a run
//  ack          out  1  run complete; held until req rises or init
//  mem_addr     out  8  DM address
//  mem_wr_en    out  1  DM write strobe (write on rising edge)
//  mem_wr_data  out  8  DM write data
//  mem_rd_data  in   8  DM read data, combinational from mem_addr
//  ptrn_idx     out  4  matched tap-pattern index 0..8; 4'hF if none
//  seed         out  7  recovered LFSR initial state
//  err          out  1  no pattern matched, or seed was zero
// BEHAVIOUR
//  - Reset (init=1): state IDLE; ack=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0, ptrn_idx=4'hF,
//    seed=0, err=0. init mid-run aborts at once; writes already done stay in DM.
//  - Launch: in IDLE, req sampled 1 then 0 on consecutive edges -> LOAD_HDR.
//    A held-low req never relaunches.
//  - LOAD_HDR (7 cycles): hdr[k] <= mem_rd_data[6:0] from MSG_BASE+k. seed <= hdr[0].
//    Preamble plaintext is 0x00 (space minus 0x20), so hdr[k] equals the LFSR state k.
//  - SEARCH (1 pattern/cycle, idx 0..8, at most 9 cycles):
//    - Step rule: next = {s[5:0], ^(s & PTRN[idx])}.
//    - Pattern idx matches when stepping from hdr[0] reproduces hdr[1..6].
//    - The first match wins and sets ptrn_idx -> DECRYPT.
//    - No match, or hdr[0]==0: err=1 -> DONE, with no DM writes.
//  - DECRYPT (2 cycles per byte, i=0..63):
//    - RD cycle: mem_addr=MSG_BASE+i; p = ((rd[6:0]^lfsr) + 8'h20), an 8-bit add.
//    - WR cycle: the lfsr register steps each byte.
//    - skip mode (initially 1):
//      - Byte is dropped while p==8'h20 and skipped<MAX_PRE.
//      - The first non-space p, or skipped==MAX_PRE, clears skip.
//      - Otherwise write p to DM[out_ptr] and increment out_ptr.
//  - PAD: while out_ptr<64, write 8'h20 to DM[out_ptr], 1 per cycle. out_ptr==64 -> DONE.
//  - DONE: ack=1 from the cycle after the last write. req rising -> IDLE, ack=0.
//  - mem_wr_en is high only in WR/PAD write cycles. DM[0..63] is never read.
//  - Latency, success case: 7 + (idx+1) + 128 + skipped + 1 cycles from launch to ack.
// CONFIGURATION
//  DECRYPT_PARITY_CHECK_EN
//  - defined: in each RD cycle compare rd[7] against ^rd[6:0].
//    Mismatches increment output par_err_cnt[6:0]; it saturates at 127 and clears on launch and init.
//    Bytes with bad parity still decrypt. LOAD_HDR also checks parity; any header mismatch sets err.
//  - undefined: bit 7 is ignored, the par_err_cnt port is absent, and err depends only on the search.
// STRUCTURE
//  - decrypt_pkg holds:
//    - LFSR_PTRN[9] = {60,48,78,72,6A,69,5C,7E,7B} (hex)
//    - state_t enum {IDLE,LOAD_HDR,SEARCH,RD,WR,PAD,DONE}
//    - MSG_BASE, SPACE=8'h20, NO_PTRN=4'hF
//  - Sub-module lfsr7: load/step register with the tap pattern as input. It is instanced once for
//    decryption; SEARCH uses a combinational 6-step unroll of the same step function from the package.
// TESTING
//  - Ptrn 0x60, seed 0x01, pre 10, "Mr. Watson, come here. I want to see you."; DM[64],DM[65]=0x81,0x82
//    -> ptrn_idx=0, seed=1, DM[0..40]=string, DM[41..63]=0x20, ack=1, err=0.
//  - Same message, ptrn 0x7B (idx 8), seed 0x55, pre 15 -> ptrn_idx=8, seed=0x55,
//    string at DM[0], ack at 7+9+128+15+1 cycles.
//  - DM[64..127] all 0x00 -> err=1, ptrn_idx=4'hF, ack=1, zero write strobes.
//  - Message starting with a space, pre 10 -> exactly MAX_PRE=15 bytes dropped;
//    the remaining spaces are kept at DM[0..].
//  - init pulsed during DECRYPT at i=20 -> next cycle ack=0, mem_wr_en=0, IDLE; a new req 1->0 reruns.
//    req held low after DONE gives no relaunch.
//  - With DECRYPT_PARITY_CHECK_EN, flip bit 7 of DM[100] -> par_err_cnt=1, err=0, output unchanged.
//    Flip bit 7 of DM[66] -> err=1.

Source files
------------

// File: rtl/msg_decrypt_engine_pkg.sv
// rtl/msg_decrypt_engine_pkg.sv - shared constants, state type and LFSR step function for the message decryptor
package msg_decrypt_engine_pkg;

    localparam logic [7:0] MSG_BASE = 8'd64;
    localparam int         MSG_LEN  = 64;
    localparam int         MAX_PRE  = 15;
    localparam int         HDR_LEN  = 7;
    localparam logic [7:0] SPACE    = 8'h20;
    localparam logic [3:0] NO_PTRN  = 4'hF;

    // Tap patterns, index 0 in the least significant slot.
    localparam logic [8:0][6:0] LFSR_PTRN = {
        7'h7B, 7'h7E, 7'h5C, 7'h69, 7'h6A, 7'h72, 7'h78, 7'h48, 7'h60
    };

    typedef enum logic [2:0] {
        IDLE,
        LOAD_HDR,
        SEARCH,
        RD,
        WR,
        PAD,
        DONE
    } state_t;

    // One LFSR advance: shift left, feedback is the parity of the tapped bits.
    function automatic logic [6:0] lfsr_step(input logic [6:0] s, input logic [6:0] ptrn);
        return {s[5:0], ^(s & ptrn)};
    endfunction

endpackage

// File: rtl/msg_decrypt_engine_if.sv
// rtl/msg_decrypt_engine_if.sv - data memory bus between the decryptor (master) and DM (slave)
interface msg_decrypt_engine_if;

    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
    logic [7:0] mem_rd_data;

    modport master (
        output mem_addr,
        output mem_wr_en,
        output mem_wr_data,
        input  mem_rd_data
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wr_data,
        output mem_rd_data
    );

endinterface

// File: rtl/msg_decrypt_engine_lfsr7.sv
// rtl/msg_decrypt_engine_lfsr7.sv - 7-bit load/step LFSR with the tap pattern as an input
module lfsr7
    import msg_decrypt_engine_pkg::*;
(
    input  logic       clk,
    input  logic       init,
    input  logic       load,
    input  logic [6:0] load_val,
    input  logic       step,
    input  logic [6:0] ptrn,
    output logic [6:0] state
);

    // Load takes priority over step so a fresh seed is never advanced in the same cycle.
    always_ff @(posedge clk) begin
        if (init) begin
            state <= '0;
        end else if (load) begin
            state <= load_val;
        end else if (step) begin
            state <= lfsr_step(state, ptrn);
        end
    end

endmodule

// File: rtl/msg_decrypt_engine.sv
// rtl/msg_decrypt_engine.sv - LFSR message decryptor top, optional DECRYPT_PARITY_CHECK_EN parity checking
module msg_decrypt_engine
    import msg_decrypt_engine_pkg::*;
(
    input  logic                 clk,
    input  logic                 init,
    input  logic                 req,
    output logic                 ack,
    msg_decrypt_engine_if.master mem,
    output logic [3:0]           ptrn_idx,
    output logic [6:0]           seed,
    output logic                 err
`ifdef DECRYPT_PARITY_CHECK_EN
    ,
    output logic [6:0]           par_err_cnt
`endif
);

    state_t     state_q, state_d;
    logic       req_q;
    logic [6:0] hdr [HDR_LEN];
    logic [2:0] hdr_k;
    logic [3:0] srch_idx;
    logic [5:0] byte_i;
    logic [6:0] out_ptr;
    logic [3:0] skipped;
    logic       skip;
    logic [7:0] p_q;
    logic [7:0] p_now;
    logic [6:0] dec_ptrn;
    logic [6:0] lfsr_q;
    logic [6:0] srch_s;
    logic       match;
    logic       hdr_zero;
    logic       drop;
    logic       launch;
    logic       lfsr_load;
    logic       lfsr_step_en;

`ifdef DECRYPT_PARITY_CHECK_EN
    logic       rd_par_bad;
    assign rd_par_bad = ^mem.mem_rd_data;
`else
    logic       unused_rd_msb;
    assign unused_rd_msb = mem.mem_rd_data[7];
`endif

    assign launch       = req_q && !req;
    assign hdr_zero     = (hdr[0] == 7'd0);
    assign p_now        = {1'b0, mem.mem_rd_data[6:0] ^ lfsr_q} + SPACE;
    assign drop         = skip && (p_q == SPACE) && (skipped != 4'(MAX_PRE));
    assign lfsr_load    = (state_q == SEARCH) && !hdr_zero && match;
    assign lfsr_step_en = (state_q == WR);

    // Candidate pattern check: unroll six steps from hdr[0] and compare against hdr[1..6].
    always_comb begin
        srch_s = hdr[0];
        match  = 1'b1;
        for (int j = 1; j < HDR_LEN; j++) begin
            srch_s = lfsr_step(srch_s, LFSR_PTRN[srch_idx]);
            if (srch_s != hdr[j]) begin
                match = 1'b0;
            end
        end
    end

    lfsr7 u_lfsr (
        .clk      (clk),
        .init     (init),
        .load     (lfsr_load),
        .load_val (hdr[0]),
        .step     (lfsr_step_en),
        .ptrn     (dec_ptrn),
        .state    (lfsr_q)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and DM bus drive; the bus idles at zero outside active cycles.
    always_comb begin
        state_d         = state_q;
        ack             = 1'b0;
        mem.mem_addr    = 8'd0;
        mem.mem_wr_en   = 1'b0;
        mem.mem_wr_data = 8'd0;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = LOAD_HDR;
                end
            end
            LOAD_HDR: begin
                mem.mem_addr = MSG_BASE + {5'd0, hdr_k};
                if (hdr_k == 3'(HDR_LEN - 1)) begin
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (hdr_zero) begin
                    state_d = DONE;
                end else if (match) begin
                    state_d = RD;
                end else if (srch_idx == 4'd8) begin
                    state_d = DONE;
                end
            end
            RD: begin
                mem.mem_addr = MSG_BASE + {2'd0, byte_i};
                state_d      = WR;
            end
            WR: begin
                if (!drop) begin
                    mem.mem_wr_en   = 1'b1;
                    mem.mem_addr    = {1'b0, out_ptr};
                    mem.mem_wr_data = p_q;
                end
                state_d = (byte_i == 6'(MSG_LEN - 1)) ? PAD : RD;
            end
            PAD: begin
                if (out_ptr[6]) begin
                    state_d = DONE;
                end else begin
                    mem.mem_wr_en   = 1'b1;
                    mem.mem_addr    = {1'b0, out_ptr};
                    mem.mem_wr_data = SPACE;
                end
            end
            DONE: begin
                ack = 1'b1;
                if (req && !req_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath: header capture, pattern search, byte decrypt, preamble skip and padding pointer.
    always_ff @(posedge clk) begin
        if (init) begin
            req_q    <= 1'b0;
            hdr_k    <= '0;
            srch_idx <= '0;
            byte_i   <= '0;
            out_ptr  <= '0;
            skipped  <= '0;
            skip     <= 1'b1;
            p_q      <= '0;
            dec_ptrn <= '0;
            ptrn_idx <= NO_PTRN;
            seed     <= '0;
            err      <= 1'b0;
            for (int k = 0; k < HDR_LEN; k++) begin
                hdr[k] <= '0;
            end
`ifdef DECRYPT_PARITY_CHECK_EN
            par_err_cnt <= '0;
`endif
        end else begin
            req_q <= req;
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        hdr_k    <= '0;
                        srch_idx <= '0;
                        byte_i   <= '0;
                        out_ptr  <= '0;
                        skipped  <= '0;
                        skip     <= 1'b1;
                        ptrn_idx <= NO_PTRN;
                        seed     <= '0;
                        err      <= 1'b0;
`ifdef DECRYPT_PARITY_CHECK_EN
                        par_err_cnt <= '0;
`endif
                    end
                end
                LOAD_HDR: begin
                    hdr[hdr_k] <= mem.mem_rd_data[6:0];
                    if (hdr_k == 3'd0) begin
                        seed <= mem.mem_rd_data[6:0];
                    end
                    hdr_k <= hdr_k + 3'd1;
`ifdef DECRYPT_PARITY_CHECK_EN
                    if (rd_par_bad) begin
                        err <= 1'b1;
                    end
`endif
                end
                SEARCH: begin
                    if (hdr_zero) begin
                        err <= 1'b1;
                    end else if (match) begin
                        ptrn_idx <= srch_idx;
                        dec_ptrn <= LFSR_PTRN[srch_idx];
                    end else if (srch_idx == 4'd8) begin
                        err <= 1'b1;
                    end else begin
                        srch_idx <= srch_idx + 4'd1;
                    end
                end
                RD: begin
                    p_q <= p_now;
`ifdef DECRYPT_PARITY_CHECK_EN
                    if (rd_par_bad && (par_err_cnt != 7'h7F)) begin
                        par_err_cnt <= par_err_cnt + 7'd1;
                    end
`endif
                end
                WR: begin
                    if (drop) begin
                        skipped <= skipped + 4'd1;
                    end else begin
                        skip    <= 1'b0;
                        out_ptr <= out_ptr + 7'd1;
                    end
                    byte_i <= byte_i + 6'd1;
                end
                PAD: begin
                    if (!out_ptr[6]) begin
                        out_ptr <= out_ptr + 7'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_msg_decrypt_engine.sv
// tb/tb_msg_decrypt_engine.sv - self-checking bench for msg_decrypt_engine with a DM write scoreboard
module tb_msg_decrypt_engine;

    localparam logic [6:0] TB_PTRN [9] = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int         pidx;
        logic [6:0] sd;
        int         pre;
        int         msg;
        int         exp_idx;
    } vec_t;

    logic       clk = 1'b0;
    logic       init;
    logic       req;
    logic       ack;
    logic [3:0] ptrn_idx;
    logic [6:0] seed;
    logic       err;
`ifdef DECRYPT_PARITY_CHECK_EN
    logic [6:0] par_err_cnt;
`endif

    logic [7:0] enc     [64];
    logic [7:0] dm_lo   [64];
    logic [7:0] exp_img [64];
    wr_t        exp_q   [$];
    wr_t        sb_e;
    bit         sb_on = 1'b0;
    int         wr_count = 0;
    int         n_checks = 0;
    int         n_errs = 0;
    string      msgs [3];
    vec_t       vecs [4];

    msg_decrypt_engine_if bus ();

    assign bus.mem_rd_data = (bus.mem_addr >= 8'd64 && bus.mem_addr < 8'd128) ? enc[bus.mem_addr[5:0]] : 8'h00;

    always #5 clk = ~clk;

    msg_decrypt_engine dut (
        .clk         (clk),
        .init        (init),
        .req         (req),
        .ack         (ack),
        .mem         (bus),
        .ptrn_idx    (ptrn_idx),
        .seed        (seed),
        .err         (err)
`ifdef DECRYPT_PARITY_CHECK_EN
        ,
        .par_err_cnt (par_err_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // DM write port model for the plaintext region.
    always @(posedge clk) begin
        if (bus.mem_wr_en && bus.mem_addr < 8'd64) begin
            dm_lo[bus.mem_addr[5:0]] <= bus.mem_wr_data;
        end
    end

    // Scoreboard: every write strobe is matched against the next expected write.
    always @(negedge clk) begin
        if (bus.mem_wr_en) begin
            wr_count++;
            if (sb_on) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL sb_extra_write: addr %0h data %0h with nothing expected", bus.mem_addr, bus.mem_wr_data);
                end else begin
                    sb_e = exp_q.pop_front();
                    check("sb_addr", 32'(bus.mem_addr), 32'(sb_e.addr));
                    check("sb_data", 32'(bus.mem_wr_data), 32'(sb_e.data));
                end
            end
        end
    end

    // Encrypt a message into enc[] and derive the expected plaintext image and write sequence.
    task automatic build(input int pidx, input logic [6:0] sd, input int pre, input string m,
                         input bit push, output int skipped);
        logic [7:0] plain [64];
        logic [6:0] s;
        logic [6:0] e7;
        int         lead;
        wr_t        w;
        s = sd;
        for (int i = 0; i < 64; i++) begin
            if (i < pre) plain[i] = 8'h20;
            else if (i - pre < m.len()) plain[i] = m[i - pre];
            else plain[i] = 8'h20;
            e7     = 7'(plain[i] - 8'h20) ^ s;
            enc[i] = {^e7, e7};
            s      = {s[5:0], ^(s & TB_PTRN[pidx])};
        end
        lead = 0;
        while (lead < 64 && plain[lead] == 8'h20) lead++;
        skipped = (lead < 15) ? lead : 15;
        for (int j = 0; j < 64; j++) begin
            exp_img[j] = (j + skipped < 64) ? plain[j + skipped] : 8'h20;
            if (push) begin
                w.addr = 8'(j);
                w.data = exp_img[j];
                exp_q.push_back(w);
            end
        end
    endtask

    task automatic run(output int lat, output bit to);
        @(negedge clk);
        req = 1'b0;
        @(posedge clk);
        lat = 0;
        to  = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            lat++;
            #1;
            if (ack) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic release_ack(input string tag);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_ack_drop"}, 32'(ack), 32'(0));
        @(negedge clk);
    endtask

    task automatic check_run(input string tag, input int exp_idx, input logic [6:0] exp_seed,
                             input int skipped, input int lat, input bit to);
        int bad;
        check({tag, "_timeout"}, 32'(to), 32'(0));
        check({tag, "_latency"}, lat, 7 + exp_idx + 1 + 128 + skipped + 1);
        check({tag, "_ack"}, 32'(ack), 32'(1));
        check({tag, "_err"}, 32'(err), 32'(0));
        check({tag, "_ptrn_idx"}, 32'(ptrn_idx), 32'(exp_idx));
        check({tag, "_seed"}, 32'(seed), 32'(exp_seed));
        check({tag, "_wr_count"}, wr_count, 64);
        check({tag, "_sb_left"}, exp_q.size(), 0);
        bad = 0;
        for (int j = 0; j < 64; j++) begin
            if (dm_lo[j] !== exp_img[j]) bad++;
        end
        check({tag, "_dm_bad_bytes"}, bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  skipped;
        int  lat;
        bit  to;
        bit  found;
        int  w0;

        msgs[0] = "Mr. Watson, come here. I want to see you.";
        msgs[1] = "      spaced out";
        msgs[2] = "Hello, DM!";
        vecs[0] = '{0, 7'h01, 10, 0, 0};
        vecs[1] = '{8, 7'h55, 15, 0, 8};
        vecs[2] = '{0, 7'h01, 10, 1, 0};
        vecs[3] = '{4, 7'h01,  7, 2, 4};
        for (int i = 0; i < 64; i++) begin
            enc[i] = 8'h00;
        end

        init = 1'b1;
        req  = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack", 32'(ack), 32'(0));
        check("rst_wr_en", 32'(bus.mem_wr_en), 32'(0));
        check("rst_addr", 32'(bus.mem_addr), 32'(0));
        check("rst_wr_data", 32'(bus.mem_wr_data), 32'(0));
        check("rst_ptrn_idx", 32'(ptrn_idx), 32'hF);
        check("rst_seed", 32'(seed), 32'(0));
        check("rst_err", 32'(err), 32'(0));
        init = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            exp_q.delete();
            wr_count = 0;
            sb_on    = 1'b1;
            build(vecs[v].pidx, vecs[v].sd, vecs[v].pre, msgs[vecs[v].msg], 1'b1, skipped);
            run(lat, to);
            check_run($sformatf("vec%0d", v), vecs[v].exp_idx, vecs[v].sd, skipped, lat, to);
            release_ack($sformatf("vec%0d", v));
        end

        // All-zero ciphertext: zero seed is an error and nothing is written.
        exp_q.delete();
        wr_count = 0;
        for (int i = 0; i < 64; i++) enc[i] = 8'h00;
        run(lat, to);
        check("zero_timeout", 32'(to), 32'(0));
        check("zero_err", 32'(err), 32'(1));
        check("zero_ptrn_idx", 32'(ptrn_idx), 32'hF);
        check("zero_wr_count", wr_count, 0);
        release_ack("zero");

        // Nonzero seed but an unreachable second header byte: no pattern matches.
        wr_count = 0;
        enc[0] = 8'h81;
        enc[1] = 8'hFF;
        run(lat, to);
        check("nomatch_timeout", 32'(to), 32'(0));
        check("nomatch_err", 32'(err), 32'(1));
        check("nomatch_ptrn_idx", 32'(ptrn_idx), 32'hF);
        check("nomatch_wr_count", wr_count, 0);
        release_ack("nomatch");

        // Abort with init while decrypting byte 20, then rerun from scratch.
        sb_on = 1'b0;
        build(0, 7'h01, 10, msgs[0], 1'b0, skipped);
        @(negedge clk);
        req = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk);
            #1;
            if (bus.mem_addr == 8'd84 && !bus.mem_wr_en) begin
                found = 1'b1;
                break;
            end
        end
        check("abort_reached_i20", 32'(found), 32'(1));
        init = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ack", 32'(ack), 32'(0));
        check("abort_wr_en", 32'(bus.mem_wr_en), 32'(0));
        check("abort_addr", 32'(bus.mem_addr), 32'(0));
        check("abort_ptrn_idx", 32'(ptrn_idx), 32'hF);
        @(negedge clk);
        init = 1'b0;
        req  = 1'b1;
        @(negedge clk);
        exp_q.delete();
        wr_count = 0;
        sb_on    = 1'b1;
        build(0, 7'h01, 10, msgs[0], 1'b1, skipped);
        run(lat, to);
        check_run("rerun", 0, 7'h01, skipped, lat, to);

        // req held low after DONE: no relaunch, ack stays up.
        w0 = wr_count;
        repeat (40) @(posedge clk);
        #1;
        check("held_low_ack", 32'(ack), 32'(1));
        check("held_low_no_writes", wr_count, w0);
        release_ack("held_low");

`ifdef DECRYPT_PARITY_CHECK_EN
        exp_q.delete();
        wr_count = 0;
        sb_on    = 1'b1;
        build(0, 7'h01, 10, msgs[0], 1'b1, skipped);
        enc[36] = enc[36] ^ 8'h80;
        run(lat, to);
        check_run("par_body", 0, 7'h01, skipped, lat, to);
        check("par_body_cnt", 32'(par_err_cnt), 32'(1));
        release_ack("par_body");

        sb_on = 1'b0;
        build(0, 7'h01, 10, msgs[0], 1'b0, skipped);
        enc[2] = enc[2] ^ 8'h80;
        run(lat, to);
        check("par_hdr_timeout", 32'(to), 32'(0));
        check("par_hdr_err", 32'(err), 32'(1));
        release_ack("par_hdr");
`endif

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
